// File: rtl/con_uart_bridge.sv
// rtl/con_uart_bridge.sv - UART command bridge driving the datamem con port (write mailbox, read any word).
// Optional inter-byte frame timeout is enabled with CON_TIMEOUT_EN.
module con_uart_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_BITS    = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                  con_clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic [3:0]            con_write,
  output logic [ADDR_BITS-1:0]  con_addr,
  output logic [DATA_WIDTH-1:0] con_in,
  input  logic [DATA_WIDTH-1:0] con_out,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef CON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_RD_ADDR, S_RD_WAIT, S_SEND
  } state_t;

  // receiver
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid, rx_ferr;

  // command FSM and transmitter
  state_t                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, addr_next;
  logic [DATA_WIDTH-1:0] word_q, word_d, word_next;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;
  logic [7:0]            tx_byte;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic                  uart_tx_q, uart_tx_d;
  logic [3:0]            con_write_q, con_write_d;
  logic [ADDR_BITS-1:0]  con_addr_q, con_addr_d;
  logic [DATA_WIDTH-1:0] con_in_q, con_in_d;
  logic                  err_q, err_d;
`ifdef CON_TIMEOUT_EN
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // mid-start resample rejects glitches shorter than half a bit
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_valid = 1'b1;
          end else begin
            rx_ferr = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    tx_word_d   = tx_word_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    uart_tx_d   = uart_tx_q;
    con_write_d = 4'h0;
    con_addr_d  = con_addr_q;
    con_in_d    = con_in_q;
    err_d       = rx_ferr;
    addr_next   = ADDR_BITS'({addr_q, rx_shift_q});
    word_next   = DATA_WIDTH'({word_q, rx_shift_q});
    tx_byte     = tx_word_q[DATA_WIDTH-1 -: 8];
`ifdef CON_TIMEOUT_EN
    to_cnt_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
          state_d = S_ADDR_HI;
          op_wr_d = (rx_shift_q == 8'h57);
          addr_d  = '0;
        end
      end
      S_ADDR_HI: begin
        if (rx_ferr) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          addr_d  = addr_next;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_ferr) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          addr_d = addr_next;
          if (op_wr_q) begin
            state_d    = S_DATA;
            byte_cnt_d = 2'd0;
          end else begin
            state_d    = S_RD_ADDR;
            con_addr_d = addr_next;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            // strobe is registered so it coincides with the WRITE state
            state_d = S_WRITE;
            if (addr_q[ADDR_BITS-1]) begin
              con_write_d = 4'hF;
              con_addr_d  = addr_q;
              con_in_d    = word_next;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_WRITE:   state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tx_word_d  = con_out;
        state_d    = S_SEND;
        tx_cnt_d   = '0;
        tx_bit_d   = 4'd0;
        byte_cnt_d = 2'd0;
        uart_tx_d  = 1'b0;
      end
      S_SEND: begin
        // tx_bit: 0 = start, 1..8 = data LSB first, 9 = stop
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (byte_cnt_q == 2'd3) begin
              state_d   = S_IDLE;
              uart_tx_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              tx_bit_d   = 4'd0;
              tx_word_d  = tx_word_q << 8;
              uart_tx_d  = 1'b0;
            end
          end else begin
            tx_bit_d  = tx_bit_q + 1'b1;
            uart_tx_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CON_TIMEOUT_EN
    if ((state_q == S_ADDR_HI || state_q == S_ADDR_LO || state_q == S_DATA) &&
        !rx_valid && !rx_ferr) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge con_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      word_q      <= '0;
      byte_cnt_q  <= 2'd0;
      tx_word_q   <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      uart_tx_q   <= 1'b1;
      con_write_q <= 4'h0;
      con_addr_q  <= '0;
      con_in_q    <= '0;
      err_q       <= 1'b0;
`ifdef CON_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_word_q   <= tx_word_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      uart_tx_q   <= uart_tx_d;
      con_write_q <= con_write_d;
      con_addr_q  <= con_addr_d;
      con_in_q    <= con_in_d;
      err_q       <= err_d;
`ifdef CON_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign uart_tx   = uart_tx_q;
  assign con_write = con_write_q;
  assign con_addr  = con_addr_q;
  assign con_in    = con_in_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/con_uart_bridge.md
Name: con_uart_bridge

Overview:
- Initiator for the data memory's protocol-controller port: the active end that drives con_write/con_addr/con_in and consumes con_out.
- Receives command frames from a host over UART (8N1, LSB first).
- Write frames deposit one word into the protocol mailbox region.
- Read frames fetch any datamem word through the con port and return it over UART TX.
- Runs entirely in the un-gated controller clock domain.

Parameters:
- CLKS_PER_BIT, 868, con_clk cycles per UART bit (100 MHz / 115200).
- ADDR_BITS, 14, width of con_addr; equals DATAMEM_BITS.
- DATA_WIDTH, 32, width of con_in and con_out; equals DATAMEM_WIDTH.
- TIMEOUT_BITS, 64, inter-byte timeout in bit periods; used only with CON_TIMEOUT_EN.

Ports:
- con_clk  in  1  controller clock (un-gated).
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input from host; asynchronous to con_clk.
- uart_tx  out  1  serial output to host; idles high.
- con_write  out  4  byte write enables to datamem; 4'hF for one cycle per accepted write.
- con_addr  out  ADDR_BITS  datamem byte address.
- con_in  out  DATA_WIDTH  write data, big-endian word.
- con_out  in  DATA_WIDTH  read data, big-endian; valid the cycle after con_addr is presented.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  one-cycle pulse on framing error, illegal write address or timeout.

Behaviour:
- Interface: one clock, con_clk. Reset rst is asynchronous and active-high.
- Reset values: uart_tx=1, con_write=0, con_addr=0, con_in=0, busy=0, err=0, FSM=IDLE, all counters 0.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser; the synchronised value resets to 1.
- RX start detection: a falling edge starts a bit counter. The line is resampled at CLKS_PER_BIT/2.
  - If it is high at that sample, the start is false and is ignored.
  - Data bits are sampled every CLKS_PER_BIT thereafter.
- RX stop bit: must sample 1. A 0 is a framing error: pulse err, discard the byte, abort any partial frame to IDLE.
- Frame formats; address and data are sent MSB byte first:
  - Write: 0x57, ADDR_HI, ADDR_LO, D3, D2, D1, D0.
  - Read: 0x52, ADDR_HI, ADDR_LO.
  - Address is {ADDR_HI,ADDR_LO}[ADDR_BITS-1:0]; the upper 2 bits are ignored.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, WRITE, RD_ADDR, RD_WAIT, SEND.
- IDLE: on byte 0x57 go to ADDR_HI with op=write; on 0x52 go to ADDR_HI with op=read. Any other byte is dropped silently.
- ADDR_HI to ADDR_LO on the next byte.
- ADDR_LO, on the next byte:
  - op=write: go to DATA.
  - op=read: go to RD_ADDR.
- DATA collects 4 bytes into the word register, shifting left by 8. After the 4th byte go to WRITE.
- WRITE lasts exactly 1 cycle, then IDLE.
  - If addr[ADDR_BITS-1]=1 (protocol mailbox): con_write=4'hF, con_addr=addr, con_in=word.
  - Otherwise con_write stays 0 and err pulses; the core region is not con-writable.
  - con_write returns to 0 the next cycle; con_addr and con_in hold their last values.
- RD_ADDR drives con_addr=addr for 1 cycle, then RD_WAIT.
- RD_WAIT lasts 1 cycle. It captures con_out into the TX shift word (synchronous-read latency of 1), then goes to SEND.
- SEND transmits 4 bytes MSB first, each framed as start(0), 8 data LSB first, stop(1), every bit CLKS_PER_BIT cycles.
  - Bytes are sent back-to-back with no idle gap; then return to IDLE.
  - RX keeps running during SEND, but any completed byte is dropped.
- Read address is unrestricted; the full datamem is readable.
- Simultaneous events:
  - A framing error pulses err in the same cycle the stop bit is sampled.
  - A framing error during SEND does not abort TX.
- Reset mid-frame or mid-TX: everything returns immediately to reset values; uart_tx goes high asynchronously.
- Counters: the bit-period counter is wide enough for CLKS_PER_BIT-1; the byte counter is 2 bits and wraps at 4.

Optional Feature:
- Macro: CON_TIMEOUT_EN.
- With it defined: in ADDR_HI, ADDR_LO or DATA, a counter reloads on each received byte. If TIMEOUT_BITS*CLKS_PER_BIT cycles pass with no byte, the FSM returns to IDLE and err pulses for 1 cycle. The counter is not active in IDLE, WRITE, RD_ADDR, RD_WAIT or SEND.
- Without it: partial frames wait indefinitely; the TIMEOUT_BITS parameter is unused.

Test Plan:
- All scenarios use CLKS_PER_BIT=4.
- Write frame 57 20 04 DE AD BE EF -> exactly one cycle with con_write=F, con_addr=14'h2004, con_in=32'hDEADBEEF; err stays 0; busy falls the next cycle.
- Write frame 57 00 10 11 22 33 44 -> con_write never asserts; err pulses 1 cycle; FSM returns to IDLE.
- Read frame 52 00 08 with the bench model returning con_out=32'hCAFEF00D one cycle after addr 14'h0008 -> uart_tx emits bytes CA FE F0 0D with correct 8N1 framing; busy stays high until after the last stop bit.
- Byte 0x41 in IDLE, then a 1-clock low glitch on uart_rx -> no state change, no err, no con_write.
- Send 57 20 00 with a stop bit forced to 0 on the third byte -> err pulses; a following valid write frame 57 20 08 00 00 00 01 writes 32'h1 to 14'h2008.
- Assert rst during SEND of the 2nd byte -> uart_tx=1 and busy=0 immediately; a subsequent read frame completes normally.
- With CON_TIMEOUT_EN: send 57 20 and then go silent -> err pulses after 64*4 cycles; busy=0.
